// File: rtl/wvb_rd_ctrl_pkg.sv
// Shared types and sizing helpers for the waveform-buffer read sequencer.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package wvb_rd_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_CAPT,
        S_HDR,
        S_READ,
        S_DRAIN
    } rd_state_t;

    localparam int HDR_START_LSB = 0;

    function automatic int hdr_stop_lsb(input int adr_w);
        return adr_w;
    endfunction

    // Room for every word that can be in the read pipeline plus the output head.
    function automatic int skid_depth(input int rd_lat);
        return rd_lat + 2;
    endfunction

endpackage

// File: rtl/wvb_skid_fifo.sv
// Register-based shift FIFO; entry 0 is the registered head driven straight out.
// Latency: push visible at head the cycle after the write.
// Backpressure: head held while pop_rdy=0; caller must never push when full.
module wvb_skid_fifo #(
    parameter int P_WIDTH = 8,
    parameter int P_DEPTH = 4,
    parameter int P_CNT_W = $clog2(P_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push_vld,
    input  logic [P_WIDTH-1:0] push_dat,
    input  logic               pop_rdy,
    output logic               head_vld,
    output logic [P_WIDTH-1:0] head_dat,
    output logic [P_CNT_W-1:0] occ
);

    logic [P_WIDTH-1:0] mem_q [P_DEPTH];
    logic [P_WIDTH-1:0] mem_d [P_DEPTH];
    logic [P_CNT_W-1:0] cnt_q, cnt_d;
    logic               pop;
    int                 wr_idx;

    assign head_vld = (cnt_q != '0);
    assign head_dat = mem_q[0];
    assign occ      = cnt_q;
    assign pop      = head_vld && pop_rdy;

    always_comb begin
        mem_d  = mem_q;
        cnt_d  = cnt_q;
        wr_idx = pop ? int'(cnt_q) - 1 : int'(cnt_q);
        if (pop) begin
            for (int i = 0; i < P_DEPTH - 1; i++) begin
                mem_d[i] = mem_q[i + 1];
            end
            cnt_d = cnt_q - P_CNT_W'(1);
        end
        if (push_vld) begin
            for (int i = 0; i < P_DEPTH; i++) begin
                if (i == wr_idx) begin
                    mem_d[i] = push_dat;
                end
            end
            cnt_d = cnt_d + P_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < P_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wvb_rd_ctrl.sv
// Pops one waveform header, presents it, then streams buffer words start..stop (wrapping).
// Latency: first word out_valid P_RD_LATENCY+1 cycles after the first address issue.
// Backpressure: addresses issued only while skid occupancy + reads in flight < depth.
module wvb_rd_ctrl
    import wvb_rd_ctrl_pkg::*;
#(
    parameter int P_DATA_WIDTH = 170,
    parameter int P_ADR_WIDTH  = 9,
    parameter int P_HDR_WIDTH  = 102,
    parameter int P_RD_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    hdr_empty,
    input  logic [P_HDR_WIDTH-1:0]  hdr_data,
    output logic                    hdr_rdreq,
    output logic [P_ADR_WIDTH-1:0]  wvb_rd_addr,
    input  logic [P_DATA_WIDTH-1:0] wvb_data,
    output logic [P_HDR_WIDTH-1:0]  out_hdr,
    output logic                    out_hdr_valid,
    input  logic                    out_hdr_ready,
    output logic [P_DATA_WIDTH-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic                    busy
);

    localparam int DEPTH    = skid_depth(P_RD_LATENCY);
    localparam int CNT_W    = $clog2(DEPTH + 1);
    localparam int REM_W    = P_ADR_WIDTH + 1;
    localparam int STOP_LSB = hdr_stop_lsb(P_ADR_WIDTH);
    localparam logic [CNT_W:0] DEPTH_V = (CNT_W + 1)'(DEPTH);

    rd_state_t               state_q, state_d;
    logic [P_HDR_WIDTH-1:0]  hdr_q, hdr_d;
    logic [P_ADR_WIDTH-1:0]  addr_q, addr_d;
    logic [REM_W-1:0]        remain_q, remain_d;
    logic [P_RD_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
    logic [P_RD_LATENCY-1:0] pipe_last_q, pipe_last_d;
    logic [CNT_W-1:0]        fifo_occ;
    logic [CNT_W-1:0]        inflight;
    logic [P_DATA_WIDTH:0]   fifo_head;
    logic                    fifo_head_vld;
    logic                    issue;
    logic                    issue_last;
    logic                    drained;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < P_RD_LATENCY; i++) begin
            inflight = inflight + CNT_W'(pipe_vld_q[i]);
        end
    end

    assign issue      = (state_q == S_READ) && (({1'b0, fifo_occ} + {1'b0, inflight}) < DEPTH_V);
    assign issue_last = (remain_q == REM_W'(1));
    // The last word may leave this very cycle, which lets DRAIN->IDLE overlap its handshake.
    assign drained    = (pipe_vld_q == '0) &&
                        ((fifo_occ == '0) || ((fifo_occ == CNT_W'(1)) && out_ready));

    always_comb begin
        pipe_vld_d     = '0;
        pipe_last_d    = '0;
        pipe_vld_d[0]  = issue;
        pipe_last_d[0] = issue && issue_last;
        for (int i = 1; i < P_RD_LATENCY; i++) begin
            pipe_vld_d[i]  = pipe_vld_q[i - 1];
            pipe_last_d[i] = pipe_last_q[i - 1];
        end
    end

    always_comb begin
        state_d       = state_q;
        hdr_d         = hdr_q;
        addr_d        = addr_q;
        remain_d      = remain_q;
        hdr_rdreq     = 1'b0;
        out_hdr_valid = 1'b0;
        case (state_q)
            S_IDLE:  if (en && !hdr_empty) state_d = S_POP;
            S_POP: begin
                hdr_rdreq = 1'b1;
                state_d   = S_CAPT;
            end
            S_CAPT: begin
                hdr_d    = hdr_data;
                addr_d   = hdr_data[HDR_START_LSB +: P_ADR_WIDTH];
                remain_d = {1'b0, hdr_data[STOP_LSB +: P_ADR_WIDTH] -
                                  hdr_data[HDR_START_LSB +: P_ADR_WIDTH]} + REM_W'(1);
                state_d  = S_HDR;
            end
            S_HDR: begin
                out_hdr_valid = 1'b1;
                if (out_hdr_ready) state_d = S_READ;
            end
            S_READ: begin
                if (issue) begin
                    addr_d   = addr_q + P_ADR_WIDTH'(1);
                    remain_d = remain_q - REM_W'(1);
                    if (issue_last) state_d = S_DRAIN;
                end
            end
            S_DRAIN: if (drained) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            hdr_q       <= '0;
            addr_q      <= '0;
            remain_q    <= '0;
            pipe_vld_q  <= '0;
            pipe_last_q <= '0;
        end else begin
            state_q     <= state_d;
            hdr_q       <= hdr_d;
            addr_q      <= addr_d;
            remain_q    <= remain_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_last_q <= pipe_last_d;
        end
    end

    wvb_skid_fifo #(
        .P_WIDTH (P_DATA_WIDTH + 1),
        .P_DEPTH (DEPTH),
        .P_CNT_W (CNT_W)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (pipe_vld_q[P_RD_LATENCY-1]),
        .push_dat ({pipe_last_q[P_RD_LATENCY-1], wvb_data}),
        .pop_rdy  (out_ready),
        .head_vld (fifo_head_vld),
        .head_dat (fifo_head),
        .occ      (fifo_occ)
    );

    assign wvb_rd_addr = addr_q;
    assign out_hdr     = hdr_q;
    assign out_valid   = fifo_head_vld;
    assign out_data    = fifo_head[P_DATA_WIDTH-1:0];
    assign out_last    = fifo_head_vld && fifo_head[P_DATA_WIDTH];
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_wvb_rd_ctrl.sv
// Directed bench for wvb_rd_ctrl with a header FIFO model and a fixed-latency buffer model.
module tb_wvb_rd_ctrl;

    localparam int DW  = 170;
    localparam int AW  = 9;
    localparam int HW  = 102;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          hdr_empty;
    logic [HW-1:0] hdr_data = '0;
    logic          hdr_rdreq;
    logic [AW-1:0] wvb_rd_addr;
    logic [DW-1:0] wvb_data;
    logic [HW-1:0] out_hdr;
    logic          out_hdr_valid;
    logic          out_hdr_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_last;
    logic          busy;

    always #5 clk = ~clk;

    wvb_rd_ctrl #(
        .P_DATA_WIDTH (DW),
        .P_ADR_WIDTH  (AW),
        .P_HDR_WIDTH  (HW),
        .P_RD_LATENCY (LAT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .hdr_empty     (hdr_empty),
        .hdr_data      (hdr_data),
        .hdr_rdreq     (hdr_rdreq),
        .wvb_rd_addr   (wvb_rd_addr),
        .wvb_data      (wvb_data),
        .out_hdr       (out_hdr),
        .out_hdr_valid (out_hdr_valid),
        .out_hdr_ready (out_hdr_ready),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_last      (out_last),
        .busy          (busy)
    );

    function automatic logic [DW-1:0] mkw(input logic [AW-1:0] a);
        return {a, ~a, {(DW - 2 * AW){1'b0}}} ^ {{(DW - AW){1'b0}}, a};
    endfunction

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Header FIFO model: data appears the cycle after a pop request.
    logic [HW-1:0] hq [16];
    int hwr = 0;
    int hrd = 0;
    assign hdr_empty = (hwr == hrd);
    always @(posedge clk) begin
        if (hdr_rdreq && (hwr != hrd)) begin
            hdr_data <= hq[hrd % 16];
            hrd      <= hrd + 1;
        end
    end

    // Buffer model with LAT cycles address-to-data.
    logic [AW-1:0] ap [LAT];
    always @(posedge clk) begin
        ap[0] <= wvb_rd_addr;
        for (int i = 1; i < LAT; i++) ap[i] <= ap[i - 1];
    end
    assign wvb_data = mkw(ap[LAT-1]);

    logic rand_rdy = 1'b0;
    always @(posedge clk) begin
        #1;
        out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    logic [DW-1:0] wd [600];
    logic          wl [600];
    int            nw = 0;
    int            nreq = 0;
    int            nhb = 0;
    int            cyc = 0;
    int            last_cyc = 0;
    int            gap = 0;
    logic [HW-1:0] last_hdr = '0;
    logic          pst = 1'b0;
    logic [DW-1:0] pdat = '0;
    logic          plast = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            pst = 1'b0;
        end else begin
            if (pst) begin
                chk("stall_vld", out_valid, 1);
                chk("stall_dat", out_data, pdat);
                chk("stall_last", out_last, plast);
            end
            if (hdr_rdreq) begin
                nreq++;
                gap = cyc - last_cyc;
            end
            if (out_hdr_valid && out_hdr_ready) begin
                nhb++;
                last_hdr = out_hdr;
            end
            if (out_valid && out_ready) begin
                if (nw < 600) begin
                    wd[nw] = out_data;
                    wl[nw] = out_last;
                end
                nw++;
                if (out_last) last_cyc = cyc;
            end
            pst   = out_valid && !out_ready;
            pdat  = out_data;
            plast = out_last;
        end
    end

    task automatic push_hdr(input logic [AW-1:0] s, input logic [AW-1:0] e, output logic [HW-1:0] h);
        h = {{(HW - 3 * AW){1'b1}}, s, e, s};
        hq[hwr % 16] = h;
        hwr++;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 0;
        bit done = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            if (busy) seen = 1;
            else if (seen) done = 1;
        end
        chk({tag, "_done"}, done, 1);
    endtask

    task automatic verify(input string tag, input int base, input logic [AW-1:0] start, input int n);
        for (int k = 0; k < n; k++) begin
            chk({tag, "_dat"}, wd[base + k], mkw(AW'(int'(start) + k)));
            chk({tag, "_last"}, wl[base + k], (k == n - 1));
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rdreq"}, hdr_rdreq, 0);
        chk({tag, "_addr"}, wvb_rd_addr, 0);
        chk({tag, "_hdr"}, out_hdr, 0);
        chk({tag, "_hvld"}, out_hdr_valid, 0);
        chk({tag, "_dat"}, out_data, 0);
        chk({tag, "_vld"}, out_valid, 0);
        chk({tag, "_last"}, out_last, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        logic [HW-1:0] h1, h2;
        int            base, nb, r0, w;
        logic          got;

        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // Basic waveform with cycle-exact timing of the control handshakes.
        en   = 1'b1;
        base = nw;
        nb   = nhb;
        push_hdr(9'd10, 9'd13, h1);
        got = 1'b0;
        w   = 0;
        while (!got && w < 20) begin
            @(negedge clk);
            w++;
            got = hdr_rdreq;
        end
        chk("rdreq_lat", w, 1);
        @(negedge clk);
        chk("capt_hvld", out_hdr_valid, 0);
        @(negedge clk);
        chk("hdr_vld", out_hdr_valid, 1);
        chk("hdr_dat", out_hdr, h1);
        @(negedge clk);
        chk("first_addr", wvb_rd_addr, 10);
        chk("hvld_drop", out_hdr_valid, 0);
        repeat (LAT) @(negedge clk);
        chk("pre_ovld", out_valid, 0);
        @(negedge clk);
        chk("first_ovld", out_valid, 1);
        chk("first_dat", out_data, mkw(9'd10));
        chk("first_last", out_last, 0);
        wait_done("basic");
        chk("basic_cnt", nw - base, 4);
        chk("basic_hbeats", nhb - nb, 1);
        verify("basic", base, 9'd10, 4);

        // Address wrap at the top of memory.
        base = nw;
        push_hdr(9'd510, 9'd1, h1);
        wait_done("wrap");
        chk("wrap_cnt", nw - base, 4);
        verify("wrap", base, 9'd510, 4);

        // Single-word waveform.
        base = nw;
        push_hdr(9'd42, 9'd42, h1);
        wait_done("single");
        chk("single_cnt", nw - base, 1);
        chk("single_hdr", last_hdr, h1);
        verify("single", base, 9'd42, 1);

        // Random back-pressure; the monitor checks output stability during stalls.
        base     = nw;
        rand_rdy = 1'b1;
        push_hdr(9'd100, 9'd115, h1);
        wait_done("bp");
        rand_rdy = 1'b0;
        chk("bp_cnt", nw - base, 16);
        verify("bp", base, 9'd100, 16);

        // Back-to-back headers: one idle cycle between last beat and the next pop.
        base = nw;
        push_hdr(9'd200, 9'd201, h1);
        push_hdr(9'd300, 9'd300, h2);
        wait_done("b2b_a");
        wait_done("b2b_b");
        chk("b2b_gap", gap, 2);
        chk("b2b_cnt", nw - base, 3);
        verify("b2b_a", base, 9'd200, 2);
        verify("b2b_b", base + 2, 9'd300, 1);

        // en dropped mid-waveform: first completes, second waits for en.
        base = nw;
        r0   = nreq;
        push_hdr(9'd5, 9'd8, h1);
        push_hdr(9'd20, 9'd21, h2);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = hdr_rdreq;
        end
        chk("en_first_pop", got, 1);
        en = 1'b0;
        wait_done("en_a");
        repeat (10) @(negedge clk);
        chk("en_hold_req", nreq - r0, 1);
        chk("en_hold_busy", busy, 0);
        chk("en_hold_cnt", nw - base, 4);
        en = 1'b1;
        wait_done("en_b");
        chk("en_req", nreq - r0, 2);
        chk("en_cnt", nw - base, 6);
        chk("en_hdr", last_hdr, h2);
        verify("en_a", base, 9'd5, 4);
        verify("en_b", base + 4, 9'd20, 2);

        // Reset in the middle of a long waveform abandons it.
        base = nw;
        push_hdr(9'd300, 9'd299, h1);
        push_hdr(9'd7, 9'd9, h2);
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            got = ((nw - base) >= 5);
        end
        chk("mid_started", got, 1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        base  = nw;
        wait_done("post_rst");
        chk("post_rst_cnt", nw - base, 3);
        chk("post_rst_hdr", last_hdr, h2);
        verify("post_rst", base, 9'd7, 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
